// File: rtl/mem_interface_unit.sv
// Memory interface unit: MAR/MDR holder and wait-state access sequencer for the 512 x 32 main memory.
// Optional address bounds check is enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_interface_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_dataout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state_r, state_next_s;
  logic [3:0]        cnt_r, cnt_next_s;
  logic              op_wr_r, op_wr_next_s;
  logic              err_r, err_next_s;
  logic [DATA_W-1:0] mar_r, mar_next_s;
  logic [DATA_W-1:0] mdr_r, mdr_next_s;
  logic [DATA_W-1:0] mar_load_s;
  logic              req_s;
  logic              oob_s;

  // A request in the same cycle as a MAR load must see the freshly loaded address
  assign mar_load_s = mar_in ? bus_in : mar_r;
  assign req_s      = rd_req | wr_req;

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob_s    = |mar_load_s[DATA_W-1:ADDR_W];
  assign addr_err = (state_r == ST_DONE) & err_r;
`else
  logic unused_s;
  assign oob_s    = 1'b0;
  assign addr_err = 1'b0;
  assign unused_s = ^{mar_r[DATA_W-1:ADDR_W], err_r};
`endif

  // Next-state and register-update logic for the access sequencer
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    op_wr_next_s = op_wr_r;
    err_next_s   = err_r;
    mar_next_s   = mar_r;
    mdr_next_s   = mdr_r;
    case (state_r)
      ST_IDLE: begin
        mar_next_s = mar_load_s;
        if (mdr_in) begin
          mdr_next_s = bus_in;
        end else begin
          mdr_next_s = mdr_r;
        end
        err_next_s = 1'b0;
        if (req_s) begin
          op_wr_next_s = wr_req;
          if (oob_s) begin
            err_next_s   = 1'b1;
            state_next_s = ST_DONE;
          end else if (WAIT_CYCLES == 0) begin
            state_next_s = ST_ACCESS;
          end else begin
            cnt_next_s   = WAIT_LOAD;
            state_next_s = ST_WAIT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_next_s = ST_ACCESS;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      ST_ACCESS: begin
        // Read data is asynchronous, so it is already valid for the whole access cycle
        if (!op_wr_r) begin
          mdr_next_s = mem_dataout;
        end else begin
          mdr_next_s = mdr_r;
        end
        state_next_s = ST_DONE;
      end
      ST_DONE: begin
        err_next_s   = 1'b0;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      op_wr_r <= 1'b0;
      err_r   <= 1'b0;
      mar_r   <= '0;
      mdr_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      op_wr_r <= op_wr_next_s;
      err_r   <= err_next_s;
      mar_r   <= mar_next_s;
      mdr_r   <= mdr_next_s;
    end
  end

  // clr gates the strobe so a clear during ACCESS cannot commit a partial write
  assign mem_write  = (state_r == ST_ACCESS) & op_wr_r & ~clr;
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);
  assign mem_addr   = mar_r[ADDR_W-1:0];
  assign mem_datain = mdr_r;
  assign mdr_out    = mdr_r;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Self-checking bench for mem_interface_unit: behavioural 512 x 32 memory plus a scoreboard of expected completions.
module tb_mem_interface_unit;

  localparam int WC = 1;

  typedef struct {
    logic [31:0] mdr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr, mar_in, mdr_in, rd_req, wr_req;
  logic [31:0] bus_in;
  logic [31:0] mdr_out, mem_datain, mem_dataout;
  logic        busy, done, addr_err, mem_write;
  logic [8:0]  mem_addr;

  logic [31:0] mem [0:511];
  logic [31:0] ref_mem [0:511];
  logic        pre_we;
  logic [8:0]  pre_a;
  logic [31:0] pre_d;

  logic [31:0] mar_m, mdr_m;
  exp_t        sb_q[$];
  exp_t        mon_e;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          d1, d2;

  always #5 clk = ~clk;

  mem_interface_unit #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .rd_req(rd_req), .wr_req(wr_req), .mdr_out(mdr_out), .busy(busy), .done(done),
    .addr_err(addr_err), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_write(mem_write), .mem_dataout(mem_dataout)
  );

  assign mem_dataout = mem[mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_write) mem[mem_addr] <= mem_datain;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard: every done pulse pops one expected completion
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("mdr_out", mdr_out, mon_e.mdr);
          check("addr_err", 32'(addr_err), 32'(mon_e.err));
        end
      end else begin
        check("addr_err_idle", 32'(addr_err), 32'd0);
      end
    end
  end

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic load(input bit is_mar, input logic [31:0] v);
    bus_in = v;
    if (is_mar) mar_in = 1'b1; else mdr_in = 1'b1;
    @(negedge clk);
    mar_in = 1'b0; mdr_in = 1'b0;
    if (is_mar) mar_m = v; else mdr_m = v;
  endtask

  // Enter and leave at a negedge; the next call's request is then sampled at the earliest legal edge
  task automatic run_req(input bit wr, input bit rd, input bit ld_mar, input logic [31:0] mar_v,
                         input bit glitch, output int done_cyc);
    bit   err;
    int   k;
    int   wr_cnt;
    exp_t e;
    if (ld_mar) begin bus_in = mar_v; mar_in = 1'b1; mar_m = mar_v; end
    wr_req = wr; rd_req = rd;
    err = 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
    err = (mar_m[31:9] != 23'd0);
`endif
    if (err) e.mdr = mdr_m;
    else if (wr) begin ref_mem[mar_m[8:0]] = mdr_m; e.mdr = mdr_m; end
    else begin mdr_m = ref_mem[mar_m[8:0]]; e.mdr = mdr_m; end
    e.err = err;
    sb_q.push_back(e);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0; mar_in = 1'b0;
    if (glitch) begin bus_in = 32'h0000_0055; mar_in = 1'b1; mdr_in = 1'b1; end
    k = 0; wr_cnt = 0;
    check("busy_start", 32'(busy), 32'd1);
    while (!done && k < 40) begin
      check("mem_addr_stable", 32'(mem_addr), 32'(mar_m[8:0]));
      if (mem_write) begin
        wr_cnt++;
        check("wr_timing", 32'(k), 32'(WC));
      end
      @(negedge clk);
      k++;
      mar_in = 1'b0; mdr_in = 1'b0;
    end
    mar_in = 1'b0; mdr_in = 1'b0;
    done_cyc = cyc;
    check("done_latency", 32'(k), err ? 32'd0 : 32'(WC + 1));
    check("write_pulses", 32'(wr_cnt), (wr && !err) ? 32'd1 : 32'd0);
    check("mem_addr_done", 32'(mem_addr), 32'(mar_m[8:0]));
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; mar_in = 1'b0; mdr_in = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    bus_in = 32'd0; pre_we = 1'b0; pre_a = 9'd0; pre_d = 32'd0;
    mar_m = 32'd0; mdr_m = 32'd0;
    @(negedge clk);
    preload(9'h000, 32'h0BAD_F00D);
    preload(9'h1FF, 32'hCAFE_01FF);
    preload(9'h030, 32'hAAAA_AAAA);
    preload(9'h010, 32'h0000_0000);
    preload(9'h020, 32'h0000_0000);
    clr = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mdr_out", mdr_out, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    mon_en = 1'b1;

    // Write then read back through a cleared MDR
    load(1'b1, 32'h0000_0010);
    load(1'b0, 32'hDEAD_BEEF);
    check("mem_datain", mem_datain, 32'hDEAD_BEEF);
    run_req(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, d1);
    check("mem_0x010", mem[9'h010], 32'hDEAD_BEEF);
    load(1'b0, 32'h0000_0000);
    check("mdr_cleared", mdr_out, 32'd0);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, d1);

    // Back-to-back reads with the MAR load in the request cycle
    run_req(1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, d1);
    run_req(1'b0, 1'b1, 1'b1, 32'h0000_01FF, 1'b0, d2);
    check("done_spacing", 32'(d2 - d1), 32'(WC + 3));

    // Simultaneous rd/wr: write wins
    load(1'b1, 32'h0000_0020);
    load(1'b0, 32'h1234_5678);
    run_req(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, d1);
    check("mem_0x020", mem[9'h020], 32'h1234_5678);

    // Loads while busy are ignored (read of 0x020 with MAR/MDR strobes mid-access)
    load(1'b0, 32'h0000_0000);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, d1);
    check("glitch_mem_addr", 32'(mem_addr), 32'h0000_0020);

    // Clear during the ACCESS cycle of a write
    load(1'b1, 32'h0000_0030);
    load(1'b0, 32'h1111_1111);
    wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    repeat (WC) @(negedge clk);
    check("acc_write_high", 32'(mem_write), 32'd1);
    clr = 1'b1;
    #1;
    check("clr_gates_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    mar_m = 32'd0; mdr_m = 32'd0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_mem_write", 32'(mem_write), 32'd0);
    check("clr_mdr_out", mdr_out, 32'd0);
    check("clr_mem_addr", 32'(mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    check("mem_0x030_intact", mem[9'h030], 32'hAAAA_AAAA);

    // Out-of-range MAR: error completion when checked, wrapped read otherwise
    load(1'b0, 32'h7777_7777);
    load(1'b1, 32'h0000_0200);
    check("wrap_mem_addr", 32'(mem_addr), 32'd0);
    run_req(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, d1);
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
